// File: rtl/full_adder.sv
//==============================================================================
// Module      : full_adder
// Description : Single-bit full adder built from xor/and/or gate primitives;
//               one link of the add_64bit ripple-carry chain.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module full_adder (
    input  wire a,
    input  wire b,
    input  wire cin,
    output wire sum,
    output wire cout
);

    wire w_p;   // propagate
    wire w_g;   // generate
    wire w_t;   // carry passed through from cin

    xor u_xor_p   (w_p, a, b);
    xor u_xor_s   (sum, w_p, cin);
    and u_and_g   (w_g, a, b);
    and u_and_t   (w_t, cin, w_p);
    or  u_or_cout (cout, w_g, w_t);

endmodule

`default_nettype wire

// File: rtl/add_64bit.sv
//==============================================================================
// Module      : add_64bit
// Description : WIDTH-bit two's-complement ripple-carry adder with carry-in and
//               signed-overflow flag; sum and overflow registered once.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module add_64bit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] sum_d;
    logic             overflow_d;
    logic [WIDTH-1:0] sum_q;
    logic             overflow_q;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .a    (a[i]),
                .b    (b[i]),
                .cin  (w_c[i]),
                .sum  (sum_d[i]),
                .cout (w_c[i+1])
            );
        end
    endgenerate

    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign overflow_d = w_c[WIDTH] ^ w_c[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    assign sum      = sum_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_add_64bit.sv
//==============================================================================
// Module      : tb_add_64bit
// Description : Self-checking bench for add_64bit with a result scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_add_64bit;

    localparam int W = 64;
    localparam logic [W-1:0] C_ONES = '1;
    localparam logic [W-1:0] C_MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] C_MINN = {1'b1, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] s;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         overflow;

    exp_t scb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    add_64bit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic mrst);
        exp_t         e;
        logic [W:0]   t;
        t   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        e.s = mrst ? '0 : t[W-1:0];
        e.o = mrst ? 1'b0 : ((ma[W-1] == mb[W-1]) && (t[W-1] != ma[W-1]));
        return e;
    endfunction

    // Drive one operand set, queue its expected result, compare after the edge.
    task automatic step(input string tag, input logic rst_in, input logic [W-1:0] a_in,
                        input logic [W-1:0] b_in, input logic cin_in,
                        input logic [W-1:0] exp_s, input logic exp_o);
        exp_t e;
        reset = rst_in;
        a     = a_in;
        b     = b_in;
        cin   = cin_in;
        e.s   = exp_s;
        e.o   = exp_o;
        scb_q.push_back(e);
        @(posedge clk);
        #1;
        if (scb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard empty got 0 expected 1", tag);
        end else begin
            e = scb_q.pop_front();
            check({tag, "_sum"}, sum, e.s);
            check({tag, "_ovf"}, {{(W-1){1'b0}}, overflow}, {{(W-1){1'b0}}, e.o});
        end
    endtask

    task automatic step_rand(input string tag, input logic rst_in, input logic [W-1:0] a_in,
                             input logic [W-1:0] b_in, input logic cin_in);
        exp_t e;
        e = model(a_in, b_in, cin_in, rst_in);
        step(tag, rst_in, a_in, b_in, cin_in, e.s, e.o);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        // Reset dominates and holds outputs at zero despite live operands.
        for (int i = 0; i < 3; i++)
            step("reset_hold", 1'b1, C_ONES, C_ONES, 1'b1, '0, 1'b0);

        step("small",      1'b0, 64'h9DE, 64'h1B2B, 1'b0, 64'h2509, 1'b0);
        step("double",     1'b0, 64'hD3,  64'hD3,   1'b0, 64'h1A6,  1'b0);
        step("negneg",     1'b0, 64'hFFFF_FFFF_FFFF_FFE7, 64'hFFFF_FFFF_FFFF_FFD4, 1'b0,
             64'hFFFF_FFFF_FFFF_FFBB, 1'b0);
        step("maxp_plus1", 1'b0, C_MAXP, 64'h1, 1'b0, C_MINN, 1'b1);
        step("minn_minn",  1'b0, C_MINN, C_MINN, 1'b0, '0, 1'b1);
        step("m1_cin",     1'b0, C_ONES, '0, 1'b1, '0, 1'b0);
        step("maxp_cin",   1'b0, C_MAXP, '0, 1'b1, C_MINN, 1'b1);
        step("cin_only",   1'b0, '0, '0, 1'b1, 64'h1, 1'b0);

        // Mid-stream reset clears for that edge only.
        step("mid_reset",  1'b1, C_MAXP, 64'h1, 1'b0, '0, 1'b0);
        step("post_reset", 1'b0, 64'h5, 64'h7, 1'b1, 64'hD, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = C_MAXP;
                1: rb = C_MINN;
                2: rb = ~ra;
                default: ;
            endcase
            step_rand("rand", 1'b0, ra, rb, rc);
        end

        if (scb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", scb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
